// File: rtl/stoch_power_n.sv
// Stochastic power unit: y encodes p^k for a unipolar input stream x encoding p (optional stats: STOCH_POWER_COUNT_EN).
// Latency: 1 cycle from accepted x to registered y/y_valid; one bit per cycle.
// Backpressure: none; x_valid low stalls the history, y must be taken when y_valid is high.
module stoch_power_n #(
  parameter int MAX_EXP = 8,
  parameter int STRIDE  = 1,
  parameter int CNT_W   = 16,
  parameter int EXP_W   = $clog2(MAX_EXP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_sel,
  input  logic             x_valid,
  input  logic             x,
  output logic             y,
  output logic             y_valid,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] samples
);

  localparam int D      = (MAX_EXP - 1) * STRIDE;
  localparam int FILL_W = $clog2(D + 1);
  localparam logic [EXP_W-1:0] K_MAX = EXP_W'(MAX_EXP);

  logic [D-1:0]      hist, hist_cur, hist_nxt;
  logic [FILL_W-1:0] fill, fill_cur, fill_nxt, w_cur;
  logic [EXP_W-1:0]  k_reg, k_cur;
  logic              taps, y_nxt, vld_nxt;

  // Working state for this cycle: start clears history/fill before the same-cycle bit uses them
  always_comb begin
    k_cur = k_reg;
    if (start) begin
      if (exp_sel == '0)
        k_cur = EXP_W'(1);
      else if (exp_sel > K_MAX)
        k_cur = K_MAX;
      else
        k_cur = exp_sel;
    end
    hist_cur = start ? '0 : hist;
    fill_cur = start ? '0 : fill;
    w_cur    = FILL_W'((32'(k_cur) - 32'd1) * STRIDE);
  end

  // Tap AND, history shift, warm-up tracking and next output bit
  always_comb begin
    taps = 1'b1;
    for (int j = 1; j < MAX_EXP; j++) begin
      if (j < int'(k_cur))
        taps = taps & hist_cur[j*STRIDE-1];
    end
    hist_nxt = hist_cur;
    fill_nxt = fill_cur;
    y_nxt    = 1'b0;
    vld_nxt  = 1'b0;
    if (x_valid) begin
      hist_nxt[0] = x;
      for (int i = 1; i < D; i++)
        hist_nxt[i] = hist_cur[i-1];
      vld_nxt  = (fill_cur == w_cur);
      y_nxt    = vld_nxt & x & taps;
      fill_nxt = (fill_cur < w_cur) ? fill_cur + 1'b1 : fill_cur;
    end
  end

  // State and output registers; reset also returns the exponent to pass-through
  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      k_reg   <= EXP_W'(1);
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      k_reg   <= k_cur;
      y       <= y_nxt;
      y_valid <= vld_nxt;
    end
  end

`ifdef STOCH_POWER_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] ones_cur, samp_cur;

  // Counters restart on start, before the same-cycle bit is counted
  always_comb begin
    ones_cur = start ? '0 : ones;
    samp_cur = start ? '0 : samples;
  end

  // Saturating statistics of valid output bits
  always_ff @(posedge clk) begin
    if (rst) begin
      ones    <= '0;
      samples <= '0;
    end else if (vld_nxt) begin
      samples <= (samp_cur == CNT_MAX) ? samp_cur : samp_cur + 1'b1;
      ones    <= (y_nxt && ones_cur != CNT_MAX) ? ones_cur + 1'b1 : ones_cur;
    end else begin
      ones    <= ones_cur;
      samples <= samp_cur;
    end
  end
`else
  assign ones    = '0;
  assign samples = '0;
`endif

endmodule

// File: tb/tb_stoch_power_n.sv
// Testbench for stoch_power_n: three instances (STRIDE 1, STRIDE 2, CNT_W 4) share one stimulus stream.
// Reference model keeps the raw accepted-bit stream and forms p^k products directly from it.
// Outputs are sampled 1 time unit after the rising edge.
module tb_stoch_power_n;
  localparam int EXP_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, x_valid, x;
  logic [EXP_W-1:0] exp_sel;
  logic y_a, v_a, y_b, v_b, y_c, v_c;
  logic [15:0] ones_a, samp_a, ones_b, samp_b;
  logic [3:0]  ones_c, samp_c;

  stoch_power_n dut_a (.clk(clk), .rst(rst), .start(start), .exp_sel(exp_sel), .x_valid(x_valid),
                       .x(x), .y(y_a), .y_valid(v_a), .ones(ones_a), .samples(samp_a));
  stoch_power_n #(.STRIDE(2)) dut_b (.clk(clk), .rst(rst), .start(start), .exp_sel(exp_sel),
                       .x_valid(x_valid), .x(x), .y(y_b), .y_valid(v_b), .ones(ones_b), .samples(samp_b));
  stoch_power_n #(.CNT_W(4)) dut_c (.clk(clk), .rst(rst), .start(start), .exp_sel(exp_sel),
                       .x_valid(x_valid), .x(x), .y(y_c), .y_valid(v_c), .ones(ones_c), .samples(samp_c));

  // reference model state
  int k_m, n_m;
  bit strm [0:1023];
  int stride_m [3] = '{1, 2, 1};
  int cmax_m   [3] = '{65535, 65535, 15};
  int ones_m [3];
  int samp_m [3];
  bit ey [3];
  bit ev [3];

  int vectors = 0;
  int miscompares = 0;

  // One clock: drive inputs, advance the model, sample and compare all instances
  task automatic step(input string tag, input bit r, input bit s, input int es, input bit xv, input bit xb);
    logic ay [3];
    logic av [3];
    logic [31:0] ao [3];
    logic [31:0] as [3];
    int eo, es_cnt, w;
    bit b;
    rst = r; start = s; exp_sel = es[EXP_W-1:0]; x_valid = xv; x = xb;
    for (int i = 0; i < 3; i++) begin ey[i] = 0; ev[i] = 0; end
    if (r) begin
      k_m = 1; n_m = 0;
      for (int i = 0; i < 3; i++) begin ones_m[i] = 0; samp_m[i] = 0; end
    end else begin
      if (s) begin
        k_m = (es == 0) ? 1 : (es > 8) ? 8 : es;
        n_m = 0;
        for (int i = 0; i < 3; i++) begin ones_m[i] = 0; samp_m[i] = 0; end
      end
      if (xv) begin
        strm[n_m] = xb;
        for (int i = 0; i < 3; i++) begin
          w = (k_m - 1) * stride_m[i];
          if (n_m >= w) begin
            b = 1;
            for (int j = 0; j < k_m; j++) b = b & strm[n_m - j*stride_m[i]];
            ev[i] = 1; ey[i] = b;
            if (samp_m[i] < cmax_m[i]) samp_m[i]++;
            if (b && ones_m[i] < cmax_m[i]) ones_m[i]++;
          end
        end
        if (n_m < 1023) n_m++;
      end
    end
    @(posedge clk); #1;
    ay[0] = y_a; av[0] = v_a; ao[0] = 32'(ones_a); as[0] = 32'(samp_a);
    ay[1] = y_b; av[1] = v_b; ao[1] = 32'(ones_b); as[1] = 32'(samp_b);
    ay[2] = y_c; av[2] = v_c; ao[2] = 32'(ones_c); as[2] = 32'(samp_c);
    for (int i = 0; i < 3; i++) begin
`ifdef STOCH_POWER_COUNT_EN
      eo = ones_m[i]; es_cnt = samp_m[i];
`else
      eo = 0; es_cnt = 0;
`endif
      vectors += 4;
      if (ay[i] !== ey[i]) begin
        miscompares++;
        $display("FAIL %s inst%0d y: got %b want %b", tag, i, ay[i], ey[i]);
      end
      if (av[i] !== ev[i]) begin
        miscompares++;
        $display("FAIL %s inst%0d y_valid: got %b want %b", tag, i, av[i], ev[i]);
      end
      if (ao[i] !== 32'(eo)) begin
        miscompares++;
        $display("FAIL %s inst%0d ones: got %0d want %0d", tag, i, ao[i], eo);
      end
      if (as[i] !== 32'(es_cnt)) begin
        miscompares++;
        $display("FAIL %s inst%0d samples: got %0d want %0d", tag, i, as[i], es_cnt);
      end
    end
  endtask

  task automatic test_reset();
    step("reset", 1, 0, 0, 0, 0);
    step("reset_x_ignored", 1, 0, 0, 1, 1);
    step("after_reset_idle", 0, 0, 0, 0, 0);
  endtask

  task automatic test_passthrough();
    bit pat [4] = '{1, 0, 1, 1};
    step("pt_start", 0, 1, 1, 0, 0);
    foreach (pat[i]) step("passthrough", 0, 0, 1, 1, pat[i]);
    step("pt_idle", 0, 0, 1, 0, 0);
  endtask

  task automatic test_warmup();
    bit pat [6] = '{1, 1, 0, 1, 1, 1};
    step("wu_start", 0, 1, 3, 0, 0);
    for (int i = 0; i < 8; i++) step("warmup_ones", 0, 0, 3, 1, 1);
    step("wu_start2", 0, 1, 3, 0, 0);
    foreach (pat[i]) step("warmup_pattern", 0, 0, 3, 1, pat[i]);
  endtask

  task automatic test_stride();
    step("st_start", 0, 1, 2, 0, 0);
    for (int i = 0; i < 12; i++) step("stride_alt", 0, 0, 2, 1, (i % 2) == 0);
  endtask

  task automatic test_stall();
    bit pat [6] = '{1, 1, 0, 1, 1, 1};
    step("stall_start", 0, 1, 3, 0, 0);
    for (int i = 0; i < 46; i++) begin
      while ($urandom_range(0, 1) == 1) step("stall_gap", 0, 0, $urandom_range(0, 15), 0, 1);
      step("stall_bit", 0, 0, 3, 1, (i < 6) ? pat[i] : ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic test_clamp();
    step("cl_zero", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("clamp_zero", 0, 0, 0, 1, $urandom_range(0, 1) == 1);
    step("cl_over", 0, 1, 11, 0, 0);
    for (int i = 0; i < 20; i++) step("clamp_over", 0, 0, 11, 1, i != 3);
    step("start_with_bit", 0, 1, 2, 1, 1);
    step("start_bit2", 0, 0, 2, 1, 1);
    for (int i = 0; i < 4; i++) step("exp_change_no_start", 0, 0, 5, 1, 1);
  endtask

  task automatic test_counters();
    step("cnt_rst", 1, 0, 0, 0, 0);
    step("cnt_start", 0, 1, 2, 0, 0);
    for (int i = 0; i < 10; i++) step("cnt_ten", 0, 0, 2, 1, 1);
    step("cnt_start2", 0, 1, 2, 0, 0);
    for (int i = 0; i < 30; i++) step("cnt_sat", 0, 0, 2, 1, 1);
    step("mid_rst", 1, 1, 5, 1, 1);
    step("post_rst_pass", 0, 0, 5, 1, 1);
    step("post_rst_pass0", 0, 0, 5, 1, 0);
  endtask

  task automatic test_random();
    int len, bias;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 7) == 0) step("rnd_rst", 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15), 1, 1);
      bias = $urandom_range(1, 7);
      step("rnd_start", 0, 1, $urandom_range(0, 15), $urandom_range(0, 1) == 1, 1);
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++)
        step("rnd_bit", 0, 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 7) < bias);
    end
  endtask

  initial begin
    rst = 1; start = 0; exp_sel = '0; x_valid = 0; x = 0;
    k_m = 1; n_m = 0;
    for (int i = 0; i < 3; i++) begin ones_m[i] = 0; samp_m[i] = 0; end
    test_reset();
    test_passthrough();
    test_warmup();
    test_stride();
    test_stall();
    test_clamp();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
